regfile_wr_sched: RTL
=====================

# regfile_wr_sched

Write-port scheduler in front of `regfile`. It shares the single regfile write port between two writers:
- the main pipeline writeback (port A, fixed priority, no backpressure);
- a late-returning multi-cycle unit such as div/mult or load return (port B, valid/ready handshake).

After reset it runs a zero-clear sweep of registers 1..NUM_REGS-1, because `regfile` storage has no reset. It also raises a pipeline stall request when port B is starved.

## Interface
- DATA_W, 32, data width (`RegBus`)
- ADDR_W, 5, register address width (`RegAddrBus`)
- NUM_REGS, 32, register count; sweep covers 1..NUM_REGS-1
- INIT_EN, 1, 1 = run the clear sweep after reset; 0 = enter RUN directly
- STARVE_LIMIT, 4, consecutive B wait cycles before stall_req; range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_we  in  1  pipeline writeback enable
- a_waddr  in  ADDR_W  pipeline writeback address
- a_wdata  in  DATA_W  pipeline writeback data
- b_valid  in  1  port B write request
- b_ready  out  1  port B accepted this cycle (combinational)
- b_waddr  in  ADDR_W  port B address
- b_wdata  in  DATA_W  port B data
- we  out  1  regfile write enable (combinational)
- waddr  out  ADDR_W  regfile write address
- wdata  out  DATA_W  regfile write data
- stall_req  out  1  registered request for the pipeline to hold writeback
- init_done  out  1  registered; high once the sweep has finished

## Operation
- States: INIT and RUN.
  - Reset enters INIT when INIT_EN=1, otherwise RUN.
  - init_ptr resets to 1.
- INIT:
  - Each cycle drives we=1, waddr=init_ptr, wdata=0, then init_ptr++.
  - After the write with init_ptr==NUM_REGS-1, the next state is RUN.
  - b_ready=0 throughout INIT.
  - a_we is ignored and the A write is dropped; the pipeline must honour stall_req=1.
- RUN mux:
  - a_we=1: we=1, waddr/wdata from A, b_ready=0.
  - a_we=0 and b_valid=1: b_ready=1, waddr/wdata from B, and we=1 unless b_waddr==0. An address-0 request is accepted with we=0.
  - Otherwise we=0, waddr=0, wdata=0.
- Starvation counter (4-bit, saturating):
  - Increments each RUN cycle with b_valid=1 and b_ready=0.
  - Clears on a B handshake, or when b_valid=0.
- stall_req:
  - Registered value is 1 in INIT.
  - In RUN, stall_req(next) = (wait_cnt(next) >= STARVE_LIMIT).
  - It therefore drops the cycle after the B handshake.
  - If a_we=1 while stall_req=1, A still wins; nothing is dropped.
- Ordering between A and B writes to the same address is the issue logic's responsibility. This block does no hazard check.
- Same-cycle A and B to the same address: A is written, B keeps waiting and writes later.

## Timing
- Reset values, held while rst=1:
  - we=0, waddr=0, wdata=0, b_ready=0
  - stall_req=1 if INIT_EN else 0
  - init_done=0 if INIT_EN else 1
  - wait_cnt=0, init_ptr=1
- Sweep length is NUM_REGS-1 cycles: writes at cycles 0..30 after the first clk edge with rst low (default).
- init_done and stall_req change at the edge that enters RUN. The first A write is honoured in that cycle.
- Latency:
  - A to regfile: 0 cycles (combinational).
  - B: written in the handshake cycle.
  - Starvation: stall_req rises at the edge where wait_cnt reaches STARVE_LIMIT.
- rst asserted mid-sweep or mid-wait: all state clears immediately. The sweep restarts at address 1 after release.
- B handshake occurs only when b_valid and b_ready are both high on a rising edge. Port B must hold b_waddr/b_wdata stable while waiting.

## Test plan
- Reset, then release with defaults -> we=1 for 31 cycles with waddr 1..31 and wdata=0; init_done=1 and stall_req=0 from cycle 31; all regfile reads return 0.
- RUN, a_we=1, a_waddr=5, a_wdata=0xDEADBEEF -> same cycle we=1, waddr=5, wdata=0xDEADBEEF; b_ready=0.
- RUN, a_we=0, b_valid=1, b_waddr=7, b_wdata=0x12345678 -> b_ready=1, we=1, waddr=7 in that cycle; next cycle b_valid=0 and we=0.
- b_valid=1 with a_we=1 held for 6 cycles, STARVE_LIMIT=4 -> stall_req=1 after the 4th wait edge; a_we dropped next cycle -> B written; stall_req=0 one edge later.
- Both requesters on address 9 (A=0x1, B=0x2) -> cycle 1 writes 0x1; B writes 0x2 on the first cycle with a_we=0.
- rst pulsed at sweep address 12 -> outputs return to reset values immediately; sweep restarts at address 1. Separately, b_waddr=0 -> b_ready=1 and we=0.

Source files
------------

// File: rtl/regfile_wr_sched.sv
//------------------------------------------------------------------------------
// Module      : regfile_wr_sched
// Description : Arbitrates the single regfile write port between pipeline
//               writeback (A) and a late-returning unit (B); zero-clears the
//               regfile after reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wr_sched #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_REGS     = 32,
    parameter int INIT_EN      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              stall_req,
    output logic              init_done
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic              c_INIT_EN   = (INIT_EN != 0);
    localparam state_t            c_RST_STATE = c_INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_FIRST_ADDR = ADDR_W'(1);
    localparam logic [3:0]        c_LIMIT     = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [ADDR_W-1:0] w_init_ptr_next;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_next;

    // Combinational outputs are gated by rst so they read idle while the
    // asynchronous reset is held, even though the state register sits in INIT.
    always_comb begin
        w_state_next    = r_state;
        w_init_ptr_next = r_init_ptr;
        w_wait_cnt_next = 4'd0;
        we              = 1'b0;
        waddr           = '0;
        wdata           = '0;
        b_ready         = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_INIT: begin
                    we              = 1'b1;
                    waddr           = r_init_ptr;
                    w_init_ptr_next = r_init_ptr + c_FIRST_ADDR;
                    if (r_init_ptr == c_LAST_ADDR) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (a_we) begin
                        we    = 1'b1;
                        waddr = a_waddr;
                        wdata = a_wdata;
                    end else if (b_valid) begin
                        b_ready = 1'b1;
                        waddr   = b_waddr;
                        wdata   = b_wdata;
                        we      = (b_waddr != '0);
                    end
                    // B waits only when A owns the port; saturate at 15.
                    if (b_valid && a_we) begin
                        w_wait_cnt_next = (r_wait_cnt == 4'hF) ? r_wait_cnt
                                                               : r_wait_cnt + 4'd1;
                    end
                end
                default: w_state_next = c_RST_STATE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_RST_STATE;
            r_init_ptr <= c_FIRST_ADDR;
            r_wait_cnt <= 4'd0;
            stall_req  <= c_INIT_EN;
            init_done  <= !c_INIT_EN;
        end else begin
            r_state    <= w_state_next;
            r_init_ptr <= w_init_ptr_next;
            r_wait_cnt <= w_wait_cnt_next;
            stall_req  <= (w_state_next == ST_INIT) || (w_wait_cnt_next >= c_LIMIT);
            init_done  <= (w_state_next == ST_RUN);
        end
    end

endmodule

`default_nettype wire
